// File: rtl/img_proc_pkg.sv
// Shared types and frame-geometry defaults for the image-processing pipeline.
package img_proc_pkg;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, TRACK} trk_state_t;

    typedef logic [10:0] coord_t;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

endpackage

// File: rtl/coord_smoother.sv
// Combinational gate test (L1 distance) and shift-based EMA step with clamp to the frame.
module coord_smoother
    import img_proc_pkg::*;
#(
    parameter int COORD_W     = $bits(coord_t),
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int ALPHA_SHIFT = 2,
    parameter int GATE        = 64
) (
    input  logic [COORD_W-1:0] i_meas_row,
    input  logic [COORD_W-1:0] i_meas_col,
    input  logic [COORD_W-1:0] i_est_row,
    input  logic [COORD_W-1:0] i_est_col,
    output logic               o_in_gate,
    output logic [COORD_W-1:0] o_ema_row,
    output logic [COORD_W-1:0] o_ema_col
);

    localparam logic [COORD_W:0]          GATE_C  = (COORD_W+1)'(GATE);
    localparam logic signed [COORD_W+1:0] ROW_MAX = (COORD_W+2)'(V_RES - 1);
    localparam logic signed [COORD_W+1:0] COL_MAX = (COORD_W+2)'(H_RES - 1);

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Two guard bits keep the signed difference and the sum free of overflow.
    function automatic logic [COORD_W-1:0] ema_step(input logic [COORD_W-1:0]          meas,
                                                    input logic [COORD_W-1:0]          est,
                                                    input logic signed [COORD_W+1:0]   max_v);
        logic signed [COORD_W+1:0] diff;
        logic signed [COORD_W+1:0] sum;
        diff = $signed({2'b00, meas}) - $signed({2'b00, est});
        sum  = $signed({2'b00, est}) + (diff >>> ALPHA_SHIFT);
        if (sum[COORD_W+1]) begin
            return '0;
        end
        if (sum > max_v) begin
            return max_v[COORD_W-1:0];
        end
        return sum[COORD_W-1:0];
    endfunction

    logic [COORD_W:0] w_dist;

    assign w_dist    = {1'b0, abs_diff(i_meas_row, i_est_row)}
                     + {1'b0, abs_diff(i_meas_col, i_est_col)};
    assign o_in_gate = (w_dist <= GATE_C);
    assign o_ema_row = ema_step(i_meas_row, i_est_row, ROW_MAX);
    assign o_ema_col = ema_step(i_meas_col, i_est_col, COL_MAX);

endmodule

// File: rtl/coord_tracker.sv
// Target tracker: detection edge -> S0 capture -> S1 gate/EMA register -> FSM, with a
// single-entry valid/ready output register that overwrites on backpressure.
module coord_tracker
    import img_proc_pkg::*;
#(
    parameter int COORD_W     = $bits(coord_t),
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int ALPHA_SHIFT = 2,
    parameter int GATE        = 64,
    parameter int ACQ_HITS    = 3,
    parameter int MAX_MISS    = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COORD_W-1:0] iRow,
    input  logic [COORD_W-1:0] iCol,
    input  logic               iVALID_COORD,
    input  logic               iFRAME_TICK,
    output logic [COORD_W-1:0] oRow,
    output logic [COORD_W-1:0] oCol,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oLOCKED,
    output logic               oLOST,
    output logic               oDROP
);

    localparam int HW = $clog2(ACQ_HITS + 1);
    localparam int MW = $clog2(MAX_MISS + 1);

    trk_state_t         r_state, w_state_next;
    logic               r_prev_vld, r_s0_vld, r_s1_vld, r_s1_gate;
    logic [COORD_W-1:0] r_meas_row, r_meas_col, r_s1_ema_row, r_s1_ema_col;
    logic               r_tick_d1, r_tick_d2;
    logic [COORD_W-1:0] r_est_row, r_est_col, w_est_row_next, w_est_col_next;
    logic [HW-1:0]      r_hits, w_hits_next;
    logic [MW-1:0]      r_misses, w_misses_next;
    logic               r_hit, w_hit_next, w_accept, w_load;
    logic [COORD_W-1:0] r_out_row, r_out_col, w_out_row_next, w_out_col_next;
    logic               r_ovalid, w_ovalid_next, r_lost, w_lost_next, r_drop, w_drop_next;
    logic               w_edge, w_in_gate;
    logic [COORD_W-1:0] w_ema_row, w_ema_col;

    assign w_edge = iVALID_COORD & ~r_prev_vld;

    coord_smoother #(
        .COORD_W    (COORD_W),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .GATE       (GATE)
    ) u_smoother (
        .i_meas_row(r_meas_row),
        .i_meas_col(r_meas_col),
        .i_est_row (r_est_row),
        .i_est_col (r_est_col),
        .o_in_gate (w_in_gate),
        .o_ema_row (w_ema_row),
        .o_ema_col (w_ema_col)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_prev_vld   <= 1'b0;
            r_s0_vld     <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s1_gate    <= 1'b0;
            r_meas_row   <= '0;
            r_meas_col   <= '0;
            r_s1_ema_row <= '0;
            r_s1_ema_col <= '0;
            r_tick_d1    <= 1'b0;
            r_tick_d2    <= 1'b0;
            r_state      <= SEARCH;
            r_est_row    <= '0;
            r_est_col    <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_hit        <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_ovalid     <= 1'b0;
            r_lost       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_prev_vld   <= iVALID_COORD;
            r_s0_vld     <= w_edge;
            if (w_edge) begin
                r_meas_row <= iRow;
                r_meas_col <= iCol;
            end
            r_s1_vld     <= r_s0_vld;
            r_s1_gate    <= w_in_gate;
            r_s1_ema_row <= w_ema_row;
            r_s1_ema_col <= w_ema_col;
            // Tick is delayed to line up with the detection pipeline so a late centroid
            // still counts for the frame that the tick closes.
            r_tick_d1    <= iFRAME_TICK;
            r_tick_d2    <= r_tick_d1;
            r_state      <= w_state_next;
            r_est_row    <= w_est_row_next;
            r_est_col    <= w_est_col_next;
            r_hits       <= w_hits_next;
            r_misses     <= w_misses_next;
            r_hit        <= w_hit_next;
            r_out_row    <= w_out_row_next;
            r_out_col    <= w_out_col_next;
            r_ovalid     <= w_ovalid_next;
            r_lost       <= w_lost_next;
            r_drop       <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_est_row_next = r_est_row;
        w_est_col_next = r_est_col;
        w_hits_next    = r_hits;
        w_misses_next  = r_misses;
        w_hit_next     = r_hit;
        w_out_row_next = r_out_row;
        w_out_col_next = r_out_col;
        w_ovalid_next  = r_ovalid & ~iREADY;
        w_lost_next    = 1'b0;
        w_drop_next    = 1'b0;
        w_accept       = 1'b0;
        w_load         = 1'b0;

        if (r_s1_vld) begin
            unique case (r_state)
                SEARCH: begin
                    w_accept       = 1'b1;
                    w_est_row_next = r_meas_row;
                    w_est_col_next = r_meas_col;
                    w_hits_next    = HW'(1);
                    w_state_next   = ACQUIRE;
                end
                ACQUIRE: begin
                    w_accept = 1'b1;
                    if (r_s1_gate) begin
                        w_hits_next = r_hits + HW'(1);
                        if (r_hits >= HW'(ACQ_HITS - 1)) begin
                            w_state_next  = TRACK;
                            w_misses_next = '0;
                        end
                    end else begin
                        w_est_row_next = r_meas_row;
                        w_est_col_next = r_meas_col;
                        w_hits_next    = HW'(1);
                    end
                end
                TRACK: begin
                    if (r_s1_gate) begin
                        w_accept       = 1'b1;
                        w_load         = 1'b1;
                        w_est_row_next = r_s1_ema_row;
                        w_est_col_next = r_s1_ema_col;
                        w_misses_next  = '0;
                    end
                end
                default: w_state_next = SEARCH;
            endcase
        end

        if (r_tick_d2) begin
            w_hit_next = 1'b0;
            if (!(r_hit | w_accept)) begin
                if (r_state == ACQUIRE) begin
                    w_state_next = SEARCH;
                end else if (r_state == TRACK) begin
                    w_misses_next = r_misses + MW'(1);
                    if (r_misses >= MW'(MAX_MISS - 1)) begin
                        w_state_next = SEARCH;
                        w_lost_next  = 1'b1;
                    end
                end
            end
        end else if (w_accept) begin
            w_hit_next = 1'b1;
        end

        if (w_load) begin
            w_out_row_next = r_s1_ema_row;
            w_out_col_next = r_s1_ema_col;
            w_ovalid_next  = 1'b1;
            w_drop_next    = r_ovalid & ~iREADY;
        end

        if (w_state_next == SEARCH && r_state != SEARCH) begin
            w_ovalid_next = 1'b0;
        end
    end

    assign oRow    = r_out_row;
    assign oCol    = r_out_col;
    assign oVALID  = r_ovalid;
    assign oLOCKED = (r_state == TRACK);
    assign oLOST   = r_lost;
    assign oDROP   = r_drop;

endmodule
